// File: rtl/shift_add_mult_ctrl_if.sv
// Operand/product handshake bundle for the shift-and-add multiplier controller.
// The controller uses the slave view; the operand source/product sink uses master.
interface shift_add_mult_ctrl_if #(
    parameter int WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a_in;
    logic [WIDTH-1:0]     b_in;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, product
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, product
    );
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// Sequential shift-and-add multiplier controller driving an external ripple-carry adder.
// Optional MULT_ZERO_SKIP_EN: zero operands go straight to DONE with product 0.
module shift_add_mult_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_add_mult_ctrl_if.slave bus,
    output logic [WIDTH-1:0]     add_x,
    output logic [WIDTH-1:0]     add_y,
    output logic                 add_cin,
    input  logic [WIDTH-1:0]     add_s,
    input  logic                 add_cout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            q     <= '0;
            m     <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        m   <= bus.a_in;
                        q   <= bus.b_in;
                        acc <= '0;
                        cnt <= '0;
`ifdef MULT_ZERO_SKIP_EN
                        if (bus.a_in == '0 || bus.b_in == '0) begin
                            q     <= '0;
                            state <= DONE;
                        end else begin
                            state <= CALC;
                        end
`else
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    // {cout, sum, Q} shifted right one place; Q[0] falls off
                    acc <= {add_cout, add_s[WIDTH-1:1]};
                    q   <= {add_s[0], q[WIDTH-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.product   = {acc, q};

    // Adder inputs are forced to zero outside CALC so the adder sees no activity
    assign add_x   = (state == CALC) ? acc : '0;
    assign add_y   = (state == CALC && q[0]) ? m : '0;
    assign add_cin = 1'b0;
endmodule
